inst_fetch_responder: RTL

- Instruction-side responder that serves the fetch requests issued by the next-PC generator.
- Accepts requests on an SRAM-like interface: `inst_req`/`inst_addr` with an `inst_addr_ok` handshake. Returns each word with a single-cycle `inst_data_ok`.
- Converts each request into a single-beat AXI read, and tracks up to DEPTH outstanding reads.
- On an exception/eret redirect, silently drops responses to stale fetches.

---
 rtl/inst_fetch_responder.sv | 89 ++++++++
 1 files changed

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder: turns SRAM-like fetch requests into single-beat AXI reads,
// tracks outstanding reads by count and discards responses made stale by a redirect.
module inst_fetch_responder #(
    parameter int DEPTH = 4,
    parameter logic [3:0] ARID_VAL = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    input  logic        inst_flush,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    output logic        inst_rerr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    localparam int W = $clog2(DEPTH + 1);

    logic          arvalid_q, arvalid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [W-1:0]  out_q, out_d;
    logic [W-1:0]  disc_q, disc_d;
    logic          data_ok_q, data_ok_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rerr_q, rerr_d;
    logic          accept, ret;
    logic          unused_in;

    assign unused_in = &{1'b0, rid, inst_addr[1:0]};

    always_comb begin
        accept    = inst_req & (~arvalid_q | arready) & (out_q < W'(DEPTH));
        // A beat with nothing outstanding is a slave protocol error; ignore it.
        ret       = rvalid & rlast & (out_q != '0);
        out_d     = out_q + W'(accept) - W'(ret);
        arvalid_d = accept | (arvalid_q & ~arready);
        araddr_d  = accept ? {inst_addr[31:2], 2'b00} : araddr_q;
        // Everything accepted up to and including the flush cycle becomes stale.
        disc_d    = inst_flush ? out_d : (ret && disc_q != '0) ? disc_q - W'(1) : disc_q;
        data_ok_d = ret & (disc_q == '0) & ~inst_flush;
        rdata_d   = ret ? rdata : rdata_q;
        rerr_d    = ret ? |rresp : rerr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            out_q     <= '0;
            disc_q    <= '0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            out_q     <= out_d;
            disc_q    <= disc_d;
            data_ok_q <= data_ok_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    assign inst_addr_ok = accept;
    assign inst_data_ok = data_ok_q;
    assign inst_rdata   = rdata_q;
    assign inst_rerr    = rerr_q;
    assign arid         = ARID_VAL;
    assign araddr       = araddr_q;
    assign arlen        = 8'd0;
    assign arsize       = 3'b010;
    assign arburst      = 2'b01;
    assign arvalid      = arvalid_q;
    assign rready       = 1'b1;
endmodule
